// File: rtl/cva6_ras_ckpt_pkg.sv
// Shared types for the checkpointable return-address stack.
package cva6_ras_ckpt_pkg;
   typedef enum logic {RAS_WRAP = 1'b0, RAS_SAT = 1'b1} ras_ovf_mode_e;
endpackage

// File: rtl/cva6_ras_ckpt.sv
// Circular return-address stack with overflow policy, same-cycle push+pop and
// {top_ptr, count} checkpoint/restore for speculative frontend prediction.
module cva6_ras_ckpt
   import cva6_ras_ckpt_pkg::*;
#(
   parameter int unsigned   VLEN      = 32,
   parameter int unsigned   RAS_DEPTH = 2,
   parameter ras_ovf_mode_e OVF_MODE  = RAS_WRAP,
   localparam int unsigned  PW        = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1,
   localparam int unsigned  CW        = $clog2(RAS_DEPTH + 1)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic [VLEN-1:0]    data_i,
   output logic               ra_valid_o,
   output logic [VLEN-1:0]    ra_o,
   output logic [PW+CW-1:0]   ckpt_o,
   input  logic               restore_i,
   input  logic [PW+CW-1:0]   restore_ckpt_i,
   output logic               empty_o,
   output logic               full_o,
   output logic               overflow_o,
   output logic               underflow_o
);

   typedef struct packed {
      logic [PW-1:0] ptr;
      logic [CW-1:0] cnt;
   } ras_ckpt_t;

   logic [VLEN-1:0] mem_q [RAS_DEPTH];
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            wr_en;
   logic [PW-1:0]   wr_idx;
   logic            empty, full;
   ras_ckpt_t       rst_ckpt;

   // Modulo arithmetic by compare so non-power-of-2 depths wrap correctly.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(RAS_DEPTH - 1)) return '0;
      else                         return p + PW'(1);
   endfunction

   function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
      if (p == '0) return PW'(RAS_DEPTH - 1);
      else         return p - PW'(1);
   endfunction

   assign rst_ckpt = ras_ckpt_t'(restore_ckpt_i);
   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == CW'(RAS_DEPTH));

   always_comb begin
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      wr_en       = 1'b0;
      wr_idx      = ptr_q;
      overflow_o  = 1'b0;
      underflow_o = 1'b0;
      if (flush_i) begin
         ptr_d = '0;
         cnt_d = '0;
      end else if (restore_i) begin
         ptr_d = rst_ckpt.ptr;
         cnt_d = rst_ckpt.cnt;
      end else if (push_i && pop_i) begin
         wr_en = 1'b1;
         if (empty) begin
            wr_idx = ptr_inc(ptr_q);
            ptr_d  = ptr_inc(ptr_q);
            cnt_d  = CW'(1);
         end
      end else if (push_i) begin
         if (!full) begin
            wr_en  = 1'b1;
            wr_idx = ptr_inc(ptr_q);
            ptr_d  = ptr_inc(ptr_q);
            cnt_d  = cnt_q + CW'(1);
         end else begin
            overflow_o = 1'b1;
            if (OVF_MODE == RAS_WRAP) begin
               wr_en  = 1'b1;
               wr_idx = ptr_inc(ptr_q);
               ptr_d  = ptr_inc(ptr_q);
            end
         end
      end else if (pop_i) begin
         if (!empty) begin
            ptr_d = ptr_dec(ptr_q);
            cnt_d = cnt_q - CW'(1);
         end else begin
            underflow_o = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
         cnt_q <= '0;
         for (int unsigned i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         if (wr_en) mem_q[wr_idx] <= data_i;
      end
   end

   assign ra_o       = mem_q[ptr_q];
   assign ra_valid_o = !empty;
   assign empty_o    = empty;
   assign full_o     = full;
   assign ckpt_o     = {ptr_q, cnt_q};

   a_cnt_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
      32'(cnt_q) <= RAS_DEPTH);
   a_ptr_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
      32'(ptr_q) < RAS_DEPTH);
   a_restore_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (restore_i && !flush_i) |->
         (32'(rst_ckpt.cnt) <= RAS_DEPTH) && (32'(rst_ckpt.ptr) < RAS_DEPTH));
   a_restore_no_write : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (restore_i && !flush_i) |-> !wr_en);
   a_restore_exact : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (restore_i && !flush_i) |=>
         (ptr_q == $past(rst_ckpt.ptr)) && (cnt_q == $past(rst_ckpt.cnt)));

endmodule

// File: tb/tb_cva6_ras_ckpt.sv
// Self-checking bench: four stack configurations driven by directed and random
// stimulus, compared with a behavioural stack model.
module tb_cva6_ras_ckpt;
   import cva6_ras_ckpt_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fl [4], pu [4], po [4], rs [4];
   logic [31:0] din [4];
   logic [7:0]  rck [4];
   logic        rv [4], emp [4], ful [4], ovf [4], unf [4];
   logic [31:0] ra [4];
   logic [2:0]  ck0, ck1;
   logic [4:0]  ck2;
   logic [3:0]  ck3;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: inst 0 D=2 WRAP, 1 D=2 SAT, 2 D=4 WRAP, 3 D=3 WRAP
   int          dep  [4] = '{2, 2, 4, 3};
   int          cwid [4] = '{2, 2, 3, 2};
   bit          msat [4] = '{0, 1, 0, 0};
   logic [31:0] m_mem [4][8];
   int          m_top [4];
   int          m_cnt [4];
   bit          e_ovf, e_unf;

   always #5 clk = ~clk;

   cva6_ras_ckpt #(.VLEN(32), .RAS_DEPTH(2), .OVF_MODE(RAS_WRAP)) u_d2w (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[0]), .push_i(pu[0]), .pop_i(po[0]),
      .data_i(din[0]), .ra_valid_o(rv[0]), .ra_o(ra[0]), .ckpt_o(ck0),
      .restore_i(rs[0]), .restore_ckpt_i(rck[0][2:0]), .empty_o(emp[0]),
      .full_o(ful[0]), .overflow_o(ovf[0]), .underflow_o(unf[0]));

   cva6_ras_ckpt #(.VLEN(32), .RAS_DEPTH(2), .OVF_MODE(RAS_SAT)) u_d2s (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[1]), .push_i(pu[1]), .pop_i(po[1]),
      .data_i(din[1]), .ra_valid_o(rv[1]), .ra_o(ra[1]), .ckpt_o(ck1),
      .restore_i(rs[1]), .restore_ckpt_i(rck[1][2:0]), .empty_o(emp[1]),
      .full_o(ful[1]), .overflow_o(ovf[1]), .underflow_o(unf[1]));

   cva6_ras_ckpt #(.VLEN(32), .RAS_DEPTH(4), .OVF_MODE(RAS_WRAP)) u_d4 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[2]), .push_i(pu[2]), .pop_i(po[2]),
      .data_i(din[2]), .ra_valid_o(rv[2]), .ra_o(ra[2]), .ckpt_o(ck2),
      .restore_i(rs[2]), .restore_ckpt_i(rck[2][4:0]), .empty_o(emp[2]),
      .full_o(ful[2]), .overflow_o(ovf[2]), .underflow_o(unf[2]));

   cva6_ras_ckpt #(.VLEN(32), .RAS_DEPTH(3), .OVF_MODE(RAS_WRAP)) u_d3 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[3]), .push_i(pu[3]), .pop_i(po[3]),
      .data_i(din[3]), .ra_valid_o(rv[3]), .ra_o(ra[3]), .ckpt_o(ck3),
      .restore_i(rs[3]), .restore_ckpt_i(rck[3][3:0]), .empty_o(emp[3]),
      .full_o(ful[3]), .overflow_o(ovf[3]), .underflow_o(unf[3]));

   function automatic logic [7:0] get_ck(input int k);
      case (k)
         0:       return {5'b0, ck0};
         1:       return {5'b0, ck1};
         2:       return {3'b0, ck2};
         default: return {4'b0, ck3};
      endcase
   endfunction

   function automatic logic [7:0] exp_ck(input int k);
      return 8'((m_top[k] << cwid[k]) | m_cnt[k]);
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 4; k++) begin
         m_top[k] = 0;
         m_cnt[k] = 0;
         for (int j = 0; j < 8; j++) m_mem[k][j] = '0;
      end
   endtask

   // Stack semantics as a circular buffer with a top index and an occupancy count.
   task automatic m_apply(input int k, input bit f, input bit p, input bit q,
                          input logic [31:0] d, input bit r, input logic [7:0] rc);
      int dd = dep[k];
      e_ovf = 0;
      e_unf = 0;
      if (f) begin
         m_top[k] = 0; m_cnt[k] = 0;
      end else if (r) begin
         m_top[k] = int'(rc) >> cwid[k];
         m_cnt[k] = int'(rc) % (1 << cwid[k]);
      end else if (p && q) begin
         if (m_cnt[k] == 0) begin
            m_top[k] = (m_top[k] + 1) % dd; m_cnt[k] = 1;
         end
         m_mem[k][m_top[k]] = d;
      end else if (p) begin
         if (m_cnt[k] < dd) begin
            m_top[k] = (m_top[k] + 1) % dd; m_mem[k][m_top[k]] = d; m_cnt[k]++;
         end else begin
            e_ovf = 1;
            if (!msat[k]) begin
               m_top[k] = (m_top[k] + 1) % dd; m_mem[k][m_top[k]] = d;
            end
         end
      end else if (q) begin
         if (m_cnt[k] > 0) begin
            m_top[k] = (m_top[k] + dd - 1) % dd; m_cnt[k]--;
         end else e_unf = 1;
      end
   endtask

   // One cycle on instance k; returns the combinational pulses seen before the edge.
   task automatic step(input int k, input bit f, input bit p, input bit q,
                       input logic [31:0] d, input bit r, input logic [7:0] rc,
                       output bit so, output bit su);
      @(negedge clk);
      fl[k] = f; pu[k] = p; po[k] = q; din[k] = d; rs[k] = r; rck[k] = rc;
      #1;
      so = ovf[k];
      su = unf[k];
      m_apply(k, f, p, q, d, r, rc);
      @(posedge clk);
      #1;
      fl[k] = 0; pu[k] = 0; po[k] = 0; rs[k] = 0;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (rv[k] !== 1'b0 || ra[k] !== 32'h0 || emp[k] !== 1'b1 || ful[k] !== 1'b0 ||
             ovf[k] !== 1'b0 || unf[k] !== 1'b0 || get_ck(k) !== 8'h0) begin
            n_fail++;
            $display("FAIL reset[%0d] rv=%b ra=%h emp=%b ful=%b ovf=%b unf=%b ck=%h want 0 0 1 0 0 0 0",
                     k, rv[k], ra[k], emp[k], ful[k], ovf[k], unf[k], get_ck(k));
         end
      end
   endtask

   task automatic test_push_pop_d2();
      bit so, su;
      step(0, 0, 1, 0, 32'h100, 0, 0, so, su);
      step(0, 0, 1, 0, 32'h200, 0, 0, so, su);
      n_tests++;
      if (ra[0] !== 32'h200 || ful[0] !== 1'b1) begin
         n_fail++; $display("FAIL d2_push2 ra=%h full=%b want 200 1", ra[0], ful[0]);
      end
      step(0, 0, 0, 1, 0, 0, 0, so, su);
      n_tests++;
      if (ra[0] !== 32'h100) begin
         n_fail++; $display("FAIL d2_pop1 ra=%h want 100", ra[0]);
      end
      step(0, 0, 0, 1, 0, 0, 0, so, su);
      n_tests++;
      if (emp[0] !== 1'b1 || rv[0] !== 1'b0) begin
         n_fail++; $display("FAIL d2_pop2 empty=%b valid=%b want 1 0", emp[0], rv[0]);
      end
   endtask

   task automatic test_wrap_d2();
      bit so, su;
      step(0, 0, 1, 0, 32'h10, 0, 0, so, su);
      step(0, 0, 1, 0, 32'h20, 0, 0, so, su);
      n_tests++;
      if (so !== 1'b0) begin
         n_fail++; $display("FAIL wrap_ovf_early ovf=%b want 0", so);
      end
      step(0, 0, 1, 0, 32'h30, 0, 0, so, su);
      n_tests++;
      if (so !== 1'b1) begin
         n_fail++; $display("FAIL wrap_ovf ovf=%b want 1", so);
      end
      n_tests++;
      if (ra[0] !== 32'h30 || ful[0] !== 1'b1) begin
         n_fail++; $display("FAIL wrap_top ra=%h full=%b want 30 1", ra[0], ful[0]);
      end
      step(0, 0, 0, 1, 0, 0, 0, so, su);
      n_tests++;
      if (ra[0] !== 32'h20) begin
         n_fail++; $display("FAIL wrap_pop1 ra=%h want 20", ra[0]);
      end
      step(0, 0, 0, 1, 0, 0, 0, so, su);
      step(0, 0, 0, 1, 0, 0, 0, so, su);
      n_tests++;
      if (su !== 1'b1 || emp[0] !== 1'b1) begin
         n_fail++; $display("FAIL wrap_unf unf=%b empty=%b want 1 1", su, emp[0]);
      end
   endtask

   task automatic test_sat_d2();
      bit so, su;
      step(1, 0, 1, 0, 32'h10, 0, 0, so, su);
      step(1, 0, 1, 0, 32'h20, 0, 0, so, su);
      step(1, 0, 1, 0, 32'h30, 0, 0, so, su);
      n_tests++;
      if (so !== 1'b1 || ra[1] !== 32'h20 || ck1[1:0] !== 2'd2) begin
         n_fail++; $display("FAIL sat_full ovf=%b ra=%h cnt=%0d want 1 20 2", so, ra[1], ck1[1:0]);
      end
      step(1, 0, 0, 1, 0, 0, 0, so, su);
      n_tests++;
      if (ra[1] !== 32'h10) begin
         n_fail++; $display("FAIL sat_pop ra=%h want 10", ra[1]);
      end
   endtask

   task automatic test_ckpt_d4();
      bit so, su;
      logic [7:0] cap;
      step(2, 0, 1, 0, 32'h40, 0, 0, so, su);
      cap = {3'b0, ck2};
      step(2, 0, 1, 0, 32'h50, 0, 0, so, su);
      step(2, 0, 0, 1, 0, 0, 0, so, su);
      step(2, 0, 0, 1, 0, 0, 0, so, su);
      step(2, 0, 0, 0, 0, 1, cap, so, su);
      n_tests++;
      if (ra[2] !== 32'h40 || ck2[2:0] !== 3'd1 || rv[2] !== 1'b1) begin
         n_fail++; $display("FAIL ckpt_restore ra=%h cnt=%0d valid=%b want 40 1 1", ra[2], ck2[2:0], rv[2]);
      end
   endtask

   task automatic test_coroutine_d4();
      bit so, su;
      step(2, 1, 0, 0, 0, 0, 0, so, su);
      step(2, 0, 1, 0, 32'h40, 0, 0, so, su);
      step(2, 0, 1, 1, 32'h44, 0, 0, so, su);
      n_tests++;
      if (ra[2] !== 32'h44 || ck2[2:0] !== 3'd1) begin
         n_fail++; $display("FAIL pushpop ra=%h cnt=%0d want 44 1", ra[2], ck2[2:0]);
      end
      step(2, 1, 0, 0, 0, 0, 0, so, su);
      step(2, 0, 1, 1, 32'h8, 0, 0, so, su);
      n_tests++;
      if (ra[2] !== 32'h8 || ck2[2:0] !== 3'd1 || su !== 1'b0) begin
         n_fail++; $display("FAIL pushpop_empty ra=%h cnt=%0d unf=%b want 8 1 0", ra[2], ck2[2:0], su);
      end
   endtask

   task automatic test_d3_and_reset();
      bit so, su;
      for (int i = 1; i <= 5; i++) step(3, 0, 1, 0, 32'(i), 0, 0, so, su);
      for (int i = 5; i >= 3; i--) begin
         n_tests++;
         if (ra[3] !== 32'(i)) begin
            n_fail++; $display("FAIL d3_pop ra=%h want %h", ra[3], 32'(i));
         end
         step(3, 0, 0, 1, 0, 0, 0, so, su);
      end
      step(3, 1, 1, 0, 32'h77, 0, 0, so, su);
      n_tests++;
      if (emp[3] !== 1'b1 || ck3[1:0] !== 2'd0) begin
         n_fail++; $display("FAIL d3_flush empty=%b cnt=%0d want 1 0", emp[3], ck3[1:0]);
      end
      step(3, 0, 1, 0, 32'h99, 0, 0, so, su);
      @(negedge clk);
      pu[3] = 1; din[3] = 32'hAB;
      #2 rst_n = 0;
      #1;
      test_reset();
      pu[3] = 0;
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      n_tests++;
      if (emp[3] !== 1'b1 || ra[3] !== 32'h0) begin
         n_fail++; $display("FAIL d3_after_rst empty=%b ra=%h want 1 0", emp[3], ra[3]);
      end
   endtask

   task automatic test_random();
      bit so, su;
      logic [7:0] saved [4];
      int k, sel;
      bit f, p, q, r;
      @(negedge clk) rst_n = 0;
      @(negedge clk) rst_n = 1;
      m_reset();
      for (int i = 0; i < 4; i++) saved[i] = '0;
      for (int it = 0; it < 600; it++) begin
         k = $urandom_range(0, 3);
         sel = $urandom_range(0, 31);
         f = (sel == 0);
         r = (sel == 1 || sel == 2);
         p = $urandom_range(0, 1) == 1;
         q = $urandom_range(0, 2) == 0;
         if ($urandom_range(0, 7) == 0) saved[k] = exp_ck(k);
         step(k, f, p, q, $urandom, r, saved[k], so, su);
         n_tests++;
         if (so !== e_ovf || su !== e_unf) begin
            n_fail++; $display("FAIL rnd_pulse[%0d] it=%0d ovf=%b unf=%b want %b %b", k, it, so, su, e_ovf, e_unf);
         end
         n_tests++;
         if (ra[k] !== m_mem[k][m_top[k]] || rv[k] !== (m_cnt[k] != 0) || emp[k] !== (m_cnt[k] == 0) ||
             ful[k] !== (m_cnt[k] == dep[k]) || get_ck(k) !== exp_ck(k)) begin
            n_fail++;
            $display("FAIL rnd_state[%0d] it=%0d ra=%h rv=%b emp=%b ful=%b ck=%h want %h %b %b %b %h",
                     k, it, ra[k], rv[k], emp[k], ful[k], get_ck(k), m_mem[k][m_top[k]],
                     m_cnt[k] != 0, m_cnt[k] == 0, m_cnt[k] == dep[k], exp_ck(k));
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         fl[k] = 0; pu[k] = 0; po[k] = 0; rs[k] = 0; din[k] = '0; rck[k] = '0;
      end
      m_reset();
      #12;
      test_reset();
      @(negedge clk) rst_n = 1;
      test_push_pop_d2();
      test_wrap_d2();
      test_sat_d2();
      test_ckpt_d4();
      test_coroutine_d4();
      test_d3_and_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
